// File: rtl/instr_fetch_sequencer.sv
// Aligns a 32-bit fetch stream into variable-length instructions for the decoder.
// Valid rises 1 cycle after enough bytes are buffered; fetch stalls once more than 12 bytes are held.

module instr_fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_flush,
   input  logic [31:0] i_flush_pc,
   input  logic        i_mem_valid,
   input  logic [31:0] i_mem_data,
   output logic        o_mem_ready,
   output logic        o_dec_valid,
   input  logic        i_dec_ready,
   output logic [95:0] o_dec_data,
   output logic [3:0]  o_instr_len,
   output logic [31:0] o_pc,
   output logic        o_unsupported
);

   typedef enum logic [1:0] {S_FETCH, S_LEN, S_WAIT, S_ISSUE} state_t;

   state_t      state_q;
   logic [7:0]  buf_q [16];
   logic [3:0]  wr_ptr_q, wr_ptr_d;
   logic [3:0]  rd_ptr_q, rd_ptr_d;
   logic [4:0]  count_q, count_d;
   logic [31:0] pc_q;
   logic        valid_q;
   logic        unsup_q;
   logic [3:0]  len_q;
   logic [95:0] data_q;

   logic        push;
   logic        pop;
   logic [3:0]  pop_len;
   logic [95:0] win;
   logic [3:0]  len_c;
   logic        unsup_c;

   function automatic logic [3:0] ext_len(input logic [1:0] md, input logic [2:0] rm,
                                          input logic [2:0] sib_base);
      logic [3:0] e;
      e = 4'd0;
      case (md)
         2'b00: begin
            if (rm == 3'b101)
               e = 4'd4;
            else if (rm == 3'b100)
               e = (sib_base == 3'b101) ? 4'd5 : 4'd1;
         end
         2'b01:   e = (rm == 3'b100) ? 4'd2 : 4'd1;
         2'b10:   e = (rm == 3'b100) ? 4'd5 : 4'd4;
         default: e = 4'd0;
      endcase
      return e;
   endfunction

   // 12-byte view starting at the oldest buffered byte; wraps around the ring.
   always_comb begin
      win = '0;
      for (int k = 0; k < 12; k++)
         win[k*8 +: 8] = buf_q[rd_ptr_q + 4'(k)];
   end

   always_comb begin : length_decode
      logic [3:0] ext;
      ext     = ext_len(win[15:14], win[10:8], win[18:16]);
      len_c   = 4'd1;
      unsup_c = 1'b0;
      case (win[7:0])
         8'h00, 8'h01, 8'h02, 8'h03, 8'h8B: len_c = 4'd2 + ext;
         8'h04:         len_c = 4'd2;
         8'h05:         len_c = 4'd5;
         8'h80, 8'h83:  len_c = 4'd3 + ext;
         8'h81:         len_c = 4'd6 + ext;
         default: begin
            len_c   = 4'd1;
            unsup_c = 1'b1;
         end
      endcase
   end

   assign o_mem_ready = i_reset && !i_flush && (count_q <= 5'd12);
   assign push        = i_mem_valid && o_mem_ready;
   assign pop         = (state_q == S_ISSUE) && i_dec_ready;
   assign pop_len     = pop ? len_q : 4'd0;
   assign count_d     = count_q + (push ? 5'd4 : 5'd0) - {1'b0, pop_len};
   assign wr_ptr_d    = push ? wr_ptr_q + 4'd4 : wr_ptr_q;
   assign rd_ptr_d    = rd_ptr_q + pop_len;

   always_ff @(posedge i_clk) begin
      if (push) begin
         for (int k = 0; k < 4; k++)
            buf_q[wr_ptr_q + 4'(k)] <= i_mem_data[k*8 +: 8];
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q  <= S_FETCH;
         count_q  <= 5'd0;
         wr_ptr_q <= 4'd0;
         rd_ptr_q <= 4'd0;
         pc_q     <= RESET_PC;
         valid_q  <= 1'b0;
         unsup_q  <= 1'b0;
         len_q    <= 4'd0;
         data_q   <= '0;
      end else if (i_flush) begin
         state_q  <= S_FETCH;
         count_q  <= 5'd0;
         wr_ptr_q <= 4'd0;
         rd_ptr_q <= 4'd0;
         pc_q     <= i_flush_pc;
         valid_q  <= 1'b0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         case (state_q)
            S_FETCH: begin
               if (count_q >= 5'd3)
                  state_q <= S_LEN;
            end
            S_LEN: begin
               len_q   <= len_c;
               unsup_q <= unsup_c;
               // Skip WAIT when the whole instruction is already buffered.
               if (count_q >= {1'b0, len_c}) begin
                  state_q <= S_ISSUE;
                  valid_q <= 1'b1;
                  data_q  <= win;
               end else begin
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (count_q >= {1'b0, len_q}) begin
                  state_q <= S_ISSUE;
                  valid_q <= 1'b1;
                  data_q  <= win;
               end
            end
            S_ISSUE: begin
               if (i_dec_ready) begin
                  state_q <= S_FETCH;
                  valid_q <= 1'b0;
                  pc_q    <= pc_q + {28'd0, len_q};
               end
            end
            default: state_q <= S_FETCH;
         endcase
      end
   end

   assign o_dec_valid   = valid_q;
   assign o_dec_data    = data_q;
   assign o_instr_len   = len_q;
   assign o_pc          = pc_q;
   assign o_unsupported = unsup_q;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed bench: byte-queue model of the instruction stream checked against the DUT every cycle.
// Outputs sampled on the falling edge; stimulus driven 1 time unit after the rising edge.

module tb_instr_fetch_sequencer;

   localparam logic [31:0] RST_PC = 32'h0;

   logic        i_clk;
   logic        i_reset;
   logic        i_flush;
   logic [31:0] i_flush_pc;
   logic        i_mem_valid;
   logic [31:0] i_mem_data;
   logic        o_mem_ready;
   logic        o_dec_valid;
   logic        i_dec_ready;
   logic [95:0] o_dec_data;
   logic [3:0]  o_instr_len;
   logic [31:0] o_pc;
   logic        o_unsupported;

   instr_fetch_sequencer #(.RESET_PC(RST_PC)) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_flush      (i_flush),
      .i_flush_pc   (i_flush_pc),
      .i_mem_valid  (i_mem_valid),
      .i_mem_data   (i_mem_data),
      .o_mem_ready  (o_mem_ready),
      .o_dec_valid  (o_dec_valid),
      .i_dec_ready  (i_dec_ready),
      .o_dec_data   (o_dec_data),
      .o_instr_len  (o_instr_len),
      .o_pc         (o_pc),
      .o_unsupported(o_unsupported)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk96(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model state: bytes accepted but not yet consumed, and the address of the first one.
   logic [7:0]  mq[$];
   logic [31:0] mpc;
   logic [31:0] txq[$];
   bit          push_seen = 0;
   bit          prev_valid = 0;
   int          cyc = 0;
   int          last_push_cyc = 0;
   int          rise_cyc = 0;

   int          log_pc[$];
   int          log_len[$];
   int          log_uns[$];
   int          log_cyc[$];
   logic [95:0] log_dat[$];

   always @(posedge i_clk) cyc <= cyc + 1;

   function automatic int ext_of(input logic [7:0] m, input logic [7:0] s);
      int md;
      int rm;
      int sibp;
      md   = int'(m[7:6]);
      rm   = int'(m[2:0]);
      sibp = (rm == 4) ? 1 : 0;
      if (md == 3) return 0;
      if (md == 1) return 1 + sibp;
      if (md == 2) return 4 + sibp;
      if (rm == 5) return 4;
      if (rm == 4) return (s[2:0] == 3'b101) ? 5 : 1;
      return 0;
   endfunction

   function automatic bit supported(input logic [7:0] op);
      return op inside {8'h00, 8'h01, 8'h02, 8'h03, 8'h8B, 8'h04, 8'h05, 8'h80, 8'h83, 8'h81};
   endfunction

   function automatic int len_of(input logic [7:0] op, input logic [7:0] m, input logic [7:0] s);
      if (op inside {8'h00, 8'h01, 8'h02, 8'h03, 8'h8B}) return 2 + ext_of(m, s);
      if (op == 8'h04) return 2;
      if (op == 8'h05) return 5;
      if (op inside {8'h80, 8'h83}) return 3 + ext_of(m, s);
      if (op == 8'h81) return 6 + ext_of(m, s);
      return 1;
   endfunction

   function automatic bit issuable();
      if (mq.size() < 3) return 0;
      return mq.size() >= len_of(mq[0], mq[1], mq[2]);
   endfunction

   always @(negedge i_clk) begin : monitor
      int          l;
      logic [95:0] exp_d;
      logic [95:0] msk;
      if (!i_reset) begin
         chk("rst_mem_ready", 32'(o_mem_ready), 32'd0);
         chk("rst_dec_valid", 32'(o_dec_valid), 32'd0);
         chk("rst_pc", o_pc, RST_PC);
         chk("rst_len", 32'(o_instr_len), 32'd0);
         chk("rst_unsup", 32'(o_unsupported), 32'd0);
         chk96("rst_data", o_dec_data, 96'd0);
         mq.delete();
         mpc        = RST_PC;
         push_seen  = 0;
         prev_valid = 0;
      end else begin
         chk("mem_ready", 32'(o_mem_ready), 32'((mq.size() <= 12) && !i_flush));
         l = 0;
         if (o_dec_valid) begin
            if (!issuable()) begin
               checks++;
               errors++;
               $display("FAIL spurious_issue: got valid with %0d model bytes expected no issue", mq.size());
            end else begin
               l     = len_of(mq[0], mq[1], mq[2]);
               exp_d = '0;
               msk   = '0;
               for (int k = 0; k < l; k++) begin
                  exp_d[k*8 +: 8] = mq[k];
                  msk[k*8 +: 8]   = 8'hFF;
               end
               chk("dec_pc", o_pc, mpc);
               chk("dec_len", 32'(o_instr_len), 32'(l));
               chk("dec_unsup", 32'(o_unsupported), 32'(!supported(mq[0])));
               chk96("dec_data", o_dec_data & msk, exp_d);
            end
            if (!prev_valid) rise_cyc = cyc;
         end
         prev_valid = o_dec_valid;
         if (i_flush) begin
            mq.delete();
            mpc       = i_flush_pc;
            push_seen = 0;
         end else begin
            if (o_dec_valid && i_dec_ready && l > 0) begin
               log_pc.push_back(int'(o_pc));
               log_len.push_back(int'(o_instr_len));
               log_uns.push_back(int'(o_unsupported));
               log_cyc.push_back(cyc);
               log_dat.push_back(o_dec_data);
               for (int k = 0; k < l; k++) void'(mq.pop_front());
               mpc = mpc + 32'(l);
            end
            push_seen = i_mem_valid && o_mem_ready;
            if (push_seen) begin
               for (int k = 0; k < 4; k++) mq.push_back(i_mem_data[k*8 +: 8]);
               last_push_cyc = cyc + 1;
            end
         end
      end
   end

   task automatic drive();
      i_mem_valid = (txq.size() > 0);
      i_mem_data  = (txq.size() > 0) ? txq[0] : 32'd0;
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
      if (push_seen && txq.size() > 0) txq.delete(0);
      drive();
   endtask

   task automatic clear_logs();
      log_pc.delete();
      log_len.delete();
      log_uns.delete();
      log_cyc.delete();
      log_dat.delete();
   endtask

   task automatic do_reset();
      i_reset = 1'b0;
      txq.delete();
      drive();
      tick();
      tick();
      i_reset = 1'b1;
      clear_logs();
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((txq.size() > 0 || issuable()) && n < 600) begin
         tick();
         n++;
      end
      chk(name, 32'(txq.size() == 0 && !issuable()), 32'd1);
      repeat (4) tick();
   endtask

   task automatic wait_issues(input string name, input int n);
      int t;
      t = 0;
      while (log_pc.size() < n && t < 100) begin
         tick();
         t++;
      end
      chk(name, 32'(log_pc.size() >= n), 32'd1);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [95:0] d;
      i_reset     = 1'b1;
      i_flush     = 1'b0;
      i_flush_pc  = 32'd0;
      i_mem_valid = 1'b0;
      i_mem_data  = 32'd0;
      i_dec_ready = 1'b0;
      #2;
      do_reset();

      // Mixed stream: lengths 2,5,3,1,1
      i_dec_ready = 1'b1;
      txq = '{32'h7805D801, 32'h8B123456, 32'h90900845, 32'h00000000};
      drive();
      drain("s1_drain");
      chk("s1_count", 32'(log_pc.size()), 32'd6);
      chk("s1_len0", 32'(log_len[0]), 32'd2);
      chk("s1_len1", 32'(log_len[1]), 32'd5);
      chk("s1_len2", 32'(log_len[2]), 32'd3);
      chk("s1_len3", 32'(log_len[3]), 32'd1);
      chk("s1_pc2", 32'(log_pc[2]), 32'd7);
      chk("s1_pc3", 32'(log_pc[3]), 32'd10);
      chk("s1_pc4", 32'(log_pc[4]), 32'd11);
      chk("s1_uns2", 32'(log_uns[2]), 32'd0);
      chk("s1_uns4", 32'(log_uns[4]), 32'd1);

      // SIB + disp32 forms, with a WAIT-to-valid latency probe
      do_reset();
      i_dec_ready = 1'b1;
      txq = '{32'hD0250403};
      drive();
      repeat (6) tick();
      txq.push_back(32'h81D3D2D1);
      drive();
      wait_issues("s2_first", 1);
      chk("s2_latency", 32'(rise_cyc - last_push_cyc), 32'd1);
      txq = '{32'hA1A08884, 32'hB1B0A3A2, 32'h9090B3B2};
      drive();
      drain("s2_drain");
      chk("s2_count", 32'(log_len.size()), 32'd2);
      chk("s2_len0", 32'(log_len[0]), 32'd7);
      chk("s2_len1", 32'(log_len[1]), 32'd11);
      chk("s2_pc1", 32'(log_pc[1]), 32'd7);
      d = log_dat[1];
      chk96("s2_data", {8'h00, d[87:0]}, {8'h00, 88'hB3B2B1B0A3A2A1A0888481});

      // Decoder backpressure for 20 cycles while the source keeps offering words
      do_reset();
      i_dec_ready = 1'b0;
      txq = '{32'h7805D801, 32'h8B123456, 32'h90900845,
              32'h7805D801, 32'h8B123456, 32'h90900845, 32'h00000000};
      drive();
      repeat (20) tick();
      chk("bp_mem_ready", 32'(o_mem_ready), 32'd0);
      chk("bp_bytes", 32'(mq.size()), 32'd16);
      chk("bp_valid", 32'(o_dec_valid), 32'd1);
      chk("bp_pc", o_pc, 32'd0);
      chk("bp_len", 32'(o_instr_len), 32'd2);
      i_dec_ready = 1'b1;
      drain("bp_drain");
      chk("bp_count", 32'(log_pc.size()), 32'd11);
      chk("bp_pc5", 32'(log_pc[5]), 32'd12);
      chk("bp_pc7", 32'(log_pc[7]), 32'd19);
      chk("bp_pc10", 32'(log_pc[10]), 32'd24);

      // 40 two-byte instructions across several ring wraps, at full rate
      do_reset();
      i_dec_ready = 1'b1;
      for (int i = 0; i < 20; i++) txq.push_back(32'hC001C001);
      txq.push_back(32'h90909090);
      drive();
      drain("wr_drain");
      chk("wr_count", 32'(log_pc.size()), 32'd42);
      for (int i = 0; i < 40; i++) chk("wr_pc", 32'(log_pc[i]), 32'(2 * i));
      for (int i = 1; i < 40; i++) chk("wr_rate", 32'(log_cyc[i] - log_cyc[i-1]), 32'd3);

      // Flush while an instruction is presented and the decoder is ready
      do_reset();
      i_dec_ready = 1'b0;
      txq = '{32'hC001C001};
      drive();
      begin : wait_valid
         int t;
         t = 0;
         while (!o_dec_valid && t < 50) begin
            tick();
            t++;
         end
         chk("fl_presented", 32'(o_dec_valid), 32'd1);
      end
      txq = '{32'hDEADBEEF};
      drive();
      i_flush     = 1'b1;
      i_flush_pc  = 32'h1000;
      i_dec_ready = 1'b1;
      tick();
      i_flush = 1'b0;
      txq.delete();
      drive();
      #1;
      chk("fl_valid", 32'(o_dec_valid), 32'd0);
      chk("fl_pc", o_pc, 32'h1000);
      chk("fl_ready", 32'(o_mem_ready), 32'd1);
      chk("fl_no_consume", 32'(log_pc.size()), 32'd0);
      txq = '{32'hC001C001, 32'h90909090};
      drive();
      drain("fl_drain");
      chk("fl_count", 32'(log_pc.size()), 32'd4);
      chk("fl_pc0", 32'(log_pc[0]), 32'h1000);
      chk("fl_pc1", 32'(log_pc[1]), 32'h1002);

      // Asynchronous reset while waiting on an 11-byte instruction with 5 bytes held
      do_reset();
      i_dec_ready = 1'b1;
      txq = '{32'h8108458B, 32'h33221184};
      drive();
      wait_issues("rw_first", 1);
      repeat (6) tick();
      chk("rw_bytes", 32'(mq.size()), 32'd5);
      chk("rw_waiting", 32'(o_dec_valid), 32'd0);
      chk("rw_len_before", 32'(o_instr_len), 32'd11);
      i_reset = 1'b0;
      #1;
      chk("rw_valid", 32'(o_dec_valid), 32'd0);
      chk("rw_ready", 32'(o_mem_ready), 32'd0);
      chk("rw_pc", o_pc, RST_PC);
      chk("rw_len", 32'(o_instr_len), 32'd0);
      chk("rw_unsup", 32'(o_unsupported), 32'd0);
      chk96("rw_data", o_dec_data, 96'd0);
      txq.delete();
      drive();
      tick();
      tick();
      i_reset = 1'b1;
      clear_logs();
      repeat (5) tick();
      chk("rw_quiet", 32'(log_pc.size()), 32'd0);
      txq = '{32'hC001C001, 32'h90909090};
      drive();
      drain("rw_drain");
      chk("rw_first_pc", 32'(log_pc[0]), RST_PC);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
